// File: rtl/rrat.sv
// Retirement register alias table: committed arch->phys map, updated by up to WAYS
// in-order retiring instructions per cycle, with same-cycle next-state map for RAT restore.
module rrat #(
   parameter int WAYS      = 4,
   parameter int PRF       = 64,
   parameter int ARCH_REGS = 32,
   localparam int PW = $clog2(PRF),
   localparam int AW = $clog2(ARCH_REGS),
   localparam int CW = $clog2(WAYS + 1)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    except,
   input  logic [WAYS-1:0]         retire_valid,
   input  logic [WAYS-1:0]         retire_has_dest,
   input  logic [WAYS*AW-1:0]      retire_arch_dest,
   input  logic [WAYS*PW-1:0]      retire_phys_dest,
   output logic [WAYS*PW-1:0]      reg_idx_wr_RRAT_new,
   output logic [WAYS*PW-1:0]      reg_idx_wr_RRAT_old,
   output logic [WAYS-1:0]         wr_en_RRAT,
   output logic [ARCH_REGS*PW-1:0] rrat_map_next,
   output logic [ARCH_REGS*PW-1:0] rrat_map,
   output logic [CW-1:0]           retire_cnt
);

   logic [PW-1:0] map_q [ARCH_REGS];
   logic [PW-1:0] map_d [ARCH_REGS];
   logic [WAYS-1:0] eff;
   logic dup_phys;

   // The map does not depend on the exception flag: the ROB has already trimmed
   // younger slots, so the group is applied as presented.
   logic unused_except;
   assign unused_except = except;

   // Slots are walked oldest first so each slot's "old" sees the effect of older
   // slots in the same group; the last writer of an arch reg naturally wins.
   always_comb begin
      map_d               = map_q;
      eff                 = '0;
      reg_idx_wr_RRAT_new = '0;
      reg_idx_wr_RRAT_old = '0;
      wr_en_RRAT          = '0;
      retire_cnt          = '0;
      for (int i = 0; i < WAYS; i++) begin
         eff[i] = retire_valid[i] & retire_has_dest[i]
                  & (retire_arch_dest[i*AW +: AW] != '0);
         if (eff[i]) begin
            reg_idx_wr_RRAT_old[i*PW +: PW] = map_d[retire_arch_dest[i*AW +: AW]];
            reg_idx_wr_RRAT_new[i*PW +: PW] = retire_phys_dest[i*PW +: PW];
            map_d[retire_arch_dest[i*AW +: AW]] = retire_phys_dest[i*PW +: PW];
            wr_en_RRAT[i] = 1'b1;
            retire_cnt    = retire_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      dup_phys = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
         for (int j = i + 1; j < WAYS; j++) begin
            if (eff[i] && eff[j] &&
                retire_phys_dest[i*PW +: PW] == retire_phys_dest[j*PW +: PW])
               dup_phys = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int a = 0; a < ARCH_REGS; a++)
            map_q[a] <= PW'(a);
      end else begin
         map_q <= map_d;
         assert (!dup_phys);
      end
   end

   generate
      for (genvar gi = 0; gi < ARCH_REGS; gi++) begin : g_map_out
         assign rrat_map[gi*PW +: PW]      = map_q[gi];
         assign rrat_map_next[gi*PW +: PW] = map_d[gi];
      end
   endgenerate

endmodule

// File: tb/tb_rrat.sv
// Directed bench for rrat: reset identity, single retire, in-group chaining, x0/no-dest
// filtering, exception restore value, retire gaps and reset overriding a retire group.
module tb_rrat;
   localparam int WAYS = 4;
   localparam int PW   = 6;
   localparam int AW   = 5;
   localparam int NA   = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic              except;
   logic [WAYS-1:0]   retire_valid;
   logic [WAYS-1:0]   retire_has_dest;
   logic [WAYS*AW-1:0] retire_arch_dest;
   logic [WAYS*PW-1:0] retire_phys_dest;
   logic [WAYS*PW-1:0] reg_idx_wr_RRAT_new;
   logic [WAYS*PW-1:0] reg_idx_wr_RRAT_old;
   logic [WAYS-1:0]   wr_en_RRAT;
   logic [NA*PW-1:0]  rrat_map_next;
   logic [NA*PW-1:0]  rrat_map;
   logic [2:0]        retire_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   rrat dut (
      .clock               (clock),
      .reset               (reset),
      .except              (except),
      .retire_valid        (retire_valid),
      .retire_has_dest     (retire_has_dest),
      .retire_arch_dest    (retire_arch_dest),
      .retire_phys_dest    (retire_phys_dest),
      .reg_idx_wr_RRAT_new (reg_idx_wr_RRAT_new),
      .reg_idx_wr_RRAT_old (reg_idx_wr_RRAT_old),
      .wr_en_RRAT          (wr_en_RRAT),
      .rrat_map_next       (rrat_map_next),
      .rrat_map            (rrat_map),
      .retire_cnt          (retire_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else
         $display("ok   %s: %0d", tag, got);
   endtask

   function automatic logic [31:0] map_at(input int a);
      return 32'(rrat_map[a*PW +: PW]);
   endfunction
   function automatic logic [31:0] next_at(input int a);
      return 32'(rrat_map_next[a*PW +: PW]);
   endfunction
   function automatic logic [31:0] old_at(input int i);
      return 32'(reg_idx_wr_RRAT_old[i*PW +: PW]);
   endfunction
   function automatic logic [31:0] new_at(input int i);
      return 32'(reg_idx_wr_RRAT_new[i*PW +: PW]);
   endfunction

   task automatic clear_in();
      except           = 1'b0;
      retire_valid     = '0;
      retire_has_dest  = '0;
      retire_arch_dest = '0;
      retire_phys_dest = '0;
   endtask

   task automatic set_slot(input int i, input logic v, input logic hd,
                           input int arch, input int phys);
      retire_valid[i]                = v;
      retire_has_dest[i]             = hd;
      retire_arch_dest[i*AW +: AW]   = AW'(arch);
      retire_phys_dest[i*PW +: PW]   = PW'(phys);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      clear_in();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;

      // 1: reset identity, idle outputs
      for (int a = 0; a < NA; a++) check($sformatf("reset_map[%0d]", a), map_at(a), 32'(a));
      check("reset_wr_en", 32'(wr_en_RRAT), 32'd0);
      check("reset_cnt", 32'(retire_cnt), 32'd0);

      // 2: single retire arch5 -> phys40
      set_slot(0, 1, 1, 5, 40);
      #1;
      check("single_new0", new_at(0), 32'd40);
      check("single_old0", old_at(0), 32'd5);
      check("single_wr_en", 32'(wr_en_RRAT), 32'b0001);
      check("single_cnt", 32'(retire_cnt), 32'd1);
      step();
      clear_in();
      #1;
      check("single_map5", map_at(5), 32'd40);

      // 3: chain on arch7
      set_slot(0, 1, 1, 7, 33);
      set_slot(1, 1, 1, 7, 34);
      set_slot(2, 1, 1, 7, 35);
      #1;
      check("chain_old0", old_at(0), 32'd7);
      check("chain_old1", old_at(1), 32'd33);
      check("chain_old2", old_at(2), 32'd34);
      check("chain_new0", new_at(0), 32'd33);
      check("chain_new1", new_at(1), 32'd34);
      check("chain_new2", new_at(2), 32'd35);
      check("chain_wr_en", 32'(wr_en_RRAT), 32'b0111);
      check("chain_cnt", 32'(retire_cnt), 32'd3);
      check("chain_next7", next_at(7), 32'd35);
      step();
      clear_in();
      #1;
      check("chain_map7", map_at(7), 32'd35);

      // 4: x0 destination and no-dest slot are ignored
      set_slot(0, 1, 1, 0, 50);
      set_slot(1, 1, 0, 9, 51);
      #1;
      check("x0_wr_en", 32'(wr_en_RRAT), 32'd0);
      check("x0_cnt", 32'(retire_cnt), 32'd0);
      check("x0_new0", new_at(0), 32'd0);
      check("x0_old1", old_at(1), 32'd0);
      step();
      clear_in();
      #1;
      check("x0_map0", map_at(0), 32'd0);
      check("x0_map9", map_at(9), 32'd9);

      // 5: exception group, restore value visible same cycle
      except = 1'b1;
      set_slot(0, 1, 1, 3, 41);
      set_slot(1, 1, 1, 4, 42);
      #1;
      check("exc_next3", next_at(3), 32'd41);
      check("exc_next4", next_at(4), 32'd42);
      check("exc_wr_en", 32'(wr_en_RRAT), 32'b0011);
      check("exc_old0", old_at(0), 32'd3);
      check("exc_old1", old_at(1), 32'd4);
      check("exc_map3_pre", map_at(3), 32'd3);
      step();
      clear_in();
      #1;
      check("exc_map3", map_at(3), 32'd41);
      check("exc_map4", map_at(4), 32'd42);

      // gap pattern 0101; invalid slots carry junk that must be ignored
      set_slot(0, 1, 1, 5, 44);
      set_slot(1, 0, 1, 5, 46);
      set_slot(2, 1, 1, 10, 45);
      set_slot(3, 0, 1, 11, 47);
      #1;
      check("gap_wr_en", 32'(wr_en_RRAT), 32'b0101);
      check("gap_cnt", 32'(retire_cnt), 32'd2);
      check("gap_old0", old_at(0), 32'd40);
      check("gap_old2", old_at(2), 32'd10);
      check("gap_new1", new_at(1), 32'd0);
      step();
      clear_in();
      #1;
      check("gap_map5", map_at(5), 32'd44);
      check("gap_map10", map_at(10), 32'd45);
      check("gap_map11", map_at(11), 32'd11);

      // 6: reset overrides a full retire group
      set_slot(0, 1, 1, 1, 50);
      set_slot(1, 1, 1, 2, 51);
      set_slot(2, 1, 1, 3, 52);
      set_slot(3, 1, 1, 4, 53);
      reset = 1'b1;
      step();
      reset = 1'b0;
      clear_in();
      #1;
      for (int a = 0; a < NA; a++) check($sformatf("rst2_map[%0d]", a), map_at(a), 32'(a));
      check("rst2_wr_en", 32'(wr_en_RRAT), 32'd0);
      check("rst2_cnt", 32'(retire_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
